// File: rtl/rx_controller.sv
// Configuration, frame buffering and statistics block placed beside RxUnit.
// Applies configuration changes only while the receiver is idle and buffers captured frames.
module rx_controller #(
    parameter int         DEPTH      = 4,
    parameter int         CNT_W      = 8,
    parameter int         RST_CYCLES = 4,
    parameter logic [1:0] DEF_BAUD   = 2'b10,
    parameter logic [1:0] DEF_PARITY = 2'b01
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_baud,
    input  logic [1:0]       cfg_parity,
    input  logic             clr_stat,
    input  logic             rx_active,
    input  logic             rx_done,
    input  logic [2:0]       rx_err,
    input  logic [7:0]       rx_data,
    output logic             rx_reset_n,
    output logic [1:0]       baud_rate,
    output logic [1:0]       parity_type,
    output logic             busy,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic [2:0]       rd_err,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, WAIT_IDLE, APPLY} state_t;

    state_t        state, state_next;
    logic [CW-1:0] rst_cnt;
    logic          reapply;
    logic [1:0]    pend_baud, pend_parity;
    logic [1:0]    new_baud, new_parity;

    // A cfg_wr in the very cycle the new setting is applied still wins.
    assign new_baud   = cfg_wr ? cfg_baud   : pend_baud;
    assign new_parity = cfg_wr ? cfg_parity : pend_parity;

    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:       if (cfg_wr) state_next = WAIT_IDLE;
            WAIT_IDLE: if (!rx_active) state_next = APPLY;
            APPLY:     if (rst_cnt == '0) state_next = (reapply || cfg_wr) ? WAIT_IDLE : RUN;
            default:   state_next = RUN;
        endcase
    end

    always_comb begin
        busy = (state != RUN);
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_baud   <= '0;
            pend_parity <= '0;
            baud_rate   <= DEF_BAUD;
            parity_type <= DEF_PARITY;
            rst_cnt     <= '0;
            reapply     <= 1'b0;
            rx_reset_n  <= 1'b0;
        end else begin
            if (cfg_wr) begin
                pend_baud   <= cfg_baud;
                pend_parity <= cfg_parity;
            end
            rx_reset_n <= (state_next != APPLY);
            if (state == WAIT_IDLE && state_next == APPLY) begin
                baud_rate   <= new_baud;
                parity_type <= new_parity;
                rst_cnt     <= CW'(RST_CYCLES - 1);
            end else if (state == APPLY && rst_cnt != '0) begin
                rst_cnt <= rst_cnt - 1'b1;
            end
            if (state == APPLY) reapply <= (state_next == APPLY) && (reapply || cfg_wr);
            else                reapply <= 1'b0;
        end
    end

    logic          done_q;
    logic          capture, push, pop, full;
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] count;

    assign capture  = rx_done && !done_q && (state != APPLY);
    assign full     = (count == OW'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign push     = capture && (!full || pop);
    assign rd_data  = rd_valid ? mem[rd_ptr][7:0]  : 8'h00;
    assign rd_err   = rd_valid ? mem[rd_ptr][10:8] : 3'b000;

    // NOTE: the storage array has no reset; empty entries are never visible because the outputs are gated by rd_valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {rx_err, rx_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            done_q <= rx_done;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Statistics: clr_stat outranks a simultaneous capture.
    always_ff @(posedge clock) begin
        if (reset || clr_stat) begin
            frame_count <= '0;
            err_count   <= '0;
            overflow    <= 1'b0;
        end else if (capture) begin
            if (frame_count != '1)           frame_count <= frame_count + 1'b1;
            if (|rx_err && err_count != '1)  err_count   <= err_count + 1'b1;
            if (full && !pop)                overflow    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_controller.sv
// Self-checking bench for rx_controller: directed scenarios plus a random phase,
// all compared every cycle against a queue-based behavioural model.
module tb_rx_controller;

    localparam int DEPTH      = 4;
    localparam int CNT_W      = 8;
    localparam int RST_CYCLES = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_wr = 1'b0;
    logic [1:0]       cfg_baud = '0, cfg_parity = '0;
    logic             clr_stat = 1'b0;
    logic             rx_active = 1'b0;
    logic             rx_done = 1'b0;
    logic [2:0]       rx_err = '0;
    logic [7:0]       rx_data = '0;
    logic             rd_ready = 1'b0;
    logic             rx_reset_n, busy, rd_valid, overflow;
    logic [1:0]       baud_rate, parity_type;
    logic [7:0]       rd_data;
    logic [2:0]       rd_err;
    logic [CNT_W-1:0] frame_count, err_count;

    rx_controller #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES),
        .DEF_BAUD(2'b10), .DEF_PARITY(2'b01)
    ) dut (
        .clock(clock), .reset(reset), .cfg_wr(cfg_wr), .cfg_baud(cfg_baud),
        .cfg_parity(cfg_parity), .clr_stat(clr_stat), .rx_active(rx_active),
        .rx_done(rx_done), .rx_err(rx_err), .rx_data(rx_data),
        .rx_reset_n(rx_reset_n), .baud_rate(baud_rate), .parity_type(parity_type),
        .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_err(rd_err), .overflow(overflow), .frame_count(frame_count),
        .err_count(err_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int lows  = 0;

    // Behavioural model: configuration phase as durations, FIFO as a queue.
    bit          m_wait, m_reapply, m_rstn, m_done_prev, m_ovf;
    int          m_apply_left, m_fc, m_ec;
    logic [1:0]  m_pend_b, m_pend_p, m_baud, m_par;
    logic [10:0] m_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit in_apply, cap, pop, drop;
        logic [1:0] nb, np;
        if (reset) begin
            m_wait = 0; m_reapply = 0; m_rstn = 0; m_done_prev = 0; m_ovf = 0;
            m_apply_left = 0; m_fc = 0; m_ec = 0;
            m_pend_b = 0; m_pend_p = 0; m_baud = 2'b10; m_par = 2'b01;
            m_q.delete();
            return;
        end
        in_apply = (m_apply_left > 0);
        cap  = rx_done && !m_done_prev && !in_apply;
        pop  = (m_q.size() > 0) && rd_ready;
        drop = cap && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (cap && !drop) m_q.push_back({rx_err, rx_data});
        if (clr_stat) begin
            m_fc = 0; m_ec = 0; m_ovf = 0;
        end else if (cap) begin
            if (m_fc < CNT_MAX) m_fc++;
            if (rx_err != 0 && m_ec < CNT_MAX) m_ec++;
            if (drop) m_ovf = 1;
        end
        nb = cfg_wr ? cfg_baud : m_pend_b;
        np = cfg_wr ? cfg_parity : m_pend_p;
        if (in_apply) begin
            if (cfg_wr) m_reapply = 1;
            m_apply_left--;
            if (m_apply_left == 0) begin
                m_wait = m_reapply;
                m_reapply = 0;
            end
        end else if (m_wait) begin
            if (!rx_active) begin
                m_baud = nb; m_par = np; m_apply_left = RST_CYCLES; m_wait = 0;
            end
        end else if (cfg_wr) begin
            m_wait = 1;
        end
        if (cfg_wr) begin
            m_pend_b = cfg_baud; m_pend_p = cfg_parity;
        end
        m_rstn = (m_apply_left == 0);
        m_done_prev = rx_done;
    endtask

    task automatic compare_all();
        check("baud_rate",   32'(baud_rate),   32'(m_baud));
        check("parity_type", 32'(parity_type), 32'(m_par));
        check("rx_reset_n",  32'(rx_reset_n),  32'(m_rstn));
        check("busy",        32'(busy),        32'(m_wait || m_apply_left > 0));
        check("rd_valid",    32'(rd_valid),    32'(m_q.size() > 0));
        check("rd_data",     32'(rd_data),     (m_q.size() > 0) ? 32'(m_q[0][7:0])  : 32'h0);
        check("rd_err",      32'(rd_err),      (m_q.size() > 0) ? 32'(m_q[0][10:8]) : 32'h0);
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("frame_count", 32'(frame_count), 32'(m_fc));
        check("err_count",   32'(err_count),   32'(m_ec));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        if (!rx_reset_n) lows++;
        compare_all();
    endtask

    task automatic frame(input logic [7:0] d, input logic [2:0] e);
        rx_data = d; rx_err = e; rx_done = 1'b1;
        cycle();
        rx_done = 1'b0;
        cycle();
    endtask

    task automatic wait_not_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            cycle();
            n++;
        end
        if (n >= 40) check(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [7:0] last;
        int         fc_before;

        // 1: reset values and a single frame
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        check("rst_baud",   32'(baud_rate),   32'h2);
        check("rst_parity", 32'(parity_type), 32'h1);
        check("rst_rstn",   32'(rx_reset_n),  32'h1);
        check("rst_valid",  32'(rd_valid),    32'h0);
        rx_data = 8'h2B; rx_err = 3'b000; rx_done = 1'b1;
        cycle();
        rx_done = 1'b0;
        check("t1_valid", 32'(rd_valid),    32'h1);
        check("t1_data",  32'(rd_data),     32'h2B);
        check("t1_fc",    32'(frame_count), 32'h1);
        check("t1_ec",    32'(err_count),   32'h0);
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        check("t1_pop", 32'(rd_valid), 32'h0);

        // 2: configuration change waits for idle, then a RST_CYCLES reset pulse
        rx_active = 1'b1;
        cfg_wr = 1'b1; cfg_baud = 2'b11; cfg_parity = 2'b10;
        cycle();
        cfg_wr = 1'b0;
        check("t2_busy", 32'(busy),      32'h1);
        check("t2_hold", 32'(baud_rate), 32'h2);
        repeat (3) cycle();
        check("t2_hold2", 32'(baud_rate), 32'h2);
        lows = 0;
        rx_active = 1'b0;
        cycle();
        check("t2_baud",   32'(baud_rate),   32'h3);
        check("t2_parity", 32'(parity_type), 32'h2);
        check("t2_rstn",   32'(rx_reset_n),  32'h0);
        wait_not_busy("t2_timeout");
        check("t2_lows", 32'(lows), 32'(RST_CYCLES));

        // 3: overflow with five frames, then in-order drain
        clr_stat = 1'b1;
        cycle();
        clr_stat = 1'b0;
        for (int i = 1; i <= 5; i++) frame(8'(i), 3'b000);
        check("t3_ovf", 32'(overflow),    32'h1);
        check("t3_fc",  32'(frame_count), 32'h5);
        rd_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            check("t3_order", 32'(rd_data), 32'(i));
            cycle();
        end
        rd_ready = 1'b0;
        check("t3_empty", 32'(rd_valid), 32'h0);

        // 4: push and pop on a full FIFO in the same cycle
        clr_stat = 1'b1;
        cycle();
        clr_stat = 1'b0;
        for (int i = 0; i < DEPTH; i++) frame(8'h10 + 8'(i), 3'b000);
        rx_data = 8'hAA; rx_err = 3'b000; rx_done = 1'b1; rd_ready = 1'b1;
        cycle();
        rx_done = 1'b0;
        check("t4_ovf", 32'(overflow), 32'h0);
        last = 8'h00;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (rd_valid) begin
                last = rd_data;
                cycle();
            end
        end
        rd_ready = 1'b0;
        check("t4_last", 32'(last), 32'hAA);

        // 5: error counter saturation and clr_stat priority over a capture
        frame(8'h00, 3'b100);
        check("t5_ec1", 32'(err_count), 32'h1);
        for (int i = 0; i < 255; i++) frame(8'($urandom), 3'($urandom_range(1, 7)));
        check("t5_ec_sat", 32'(err_count),   32'hFF);
        check("t5_fc_sat", 32'(frame_count), 32'hFF);
        rx_data = 8'h55; rx_done = 1'b1; clr_stat = 1'b1;
        cycle();
        rx_done = 1'b0; clr_stat = 1'b0;
        check("t5_clr_fc",  32'(frame_count), 32'h0);
        check("t5_clr_ec",  32'(err_count),   32'h0);
        check("t5_clr_ovf", 32'(overflow),    32'h0);
        cycle();
        check("t5_uncounted", 32'(frame_count), 32'h0);

        // 6: cfg_wr during APPLY forces a second reset pulse; frames in APPLY are dropped
        rd_ready = 1'b1;
        repeat (DEPTH + 1) cycle();
        rd_ready = 1'b0;
        lows = 0;
        rx_active = 1'b0;
        cfg_wr = 1'b1; cfg_baud = 2'b00; cfg_parity = 2'b00;
        cycle();
        cfg_wr = 1'b0;
        cycle();
        cfg_wr = 1'b1; cfg_baud = 2'b01; cfg_parity = 2'b11;
        cycle();
        cfg_wr = 1'b0;
        fc_before = m_fc;
        rx_data = 8'h77; rx_done = 1'b1;
        cycle();
        rx_done = 1'b0;
        check("t6_nocount", 32'(frame_count), 32'(fc_before));
        check("t6_nopush",  32'(rd_valid),    32'h0);
        wait_not_busy("t6_timeout");
        check("t6_lows",   32'(lows),        32'(2 * RST_CYCLES));
        check("t6_baud",   32'(baud_rate),   32'h1);
        check("t6_parity", 32'(parity_type), 32'h3);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            cfg_wr     = ($urandom_range(0, 19) == 0);
            cfg_baud   = 2'($urandom);
            cfg_parity = 2'($urandom);
            clr_stat   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) rx_active = ~rx_active;
            rx_done    = ($urandom_range(0, 2) == 0);
            rx_err     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            rx_data    = 8'($urandom);
            rd_ready   = ($urandom_range(0, 1) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
